regfile_writeback: RTL and testbench

- Per-lane write-side initiator for the lane register file. It drives REG_WRITE, rd and reg_write_data.
- Accepts results from two producers:
  - the ALU, with a single-cycle valid/ready handshake;
  - the load/store path, whose variable-latency returns go into a small FIFO.
- Arbitrates between them, holds one staged write, and releases it only during SIMD_UPDATE.
- Drops writes to read-only registers (R28–R31) and flags them.

---
 rtl/regfile_writeback_if.sv | 41 ++++
 rtl/regfile_writeback.sv | 151 +++++++++++++++
 tb/tb_regfile_writeback.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// Bundles the ALU result handshake, the load-return handshake and the register-file write port.
// Latency: none (wires only).
// Backpressure: alu_ready / mem_ready flow from the writeback block back to the producers.
`ifndef SIMD_UPDATE
`define SIMD_UPDATE 3'd3
`endif

interface regfile_writeback_if #(
  parameter int DATA_WIDTH          = 64,
  parameter int DATA_REG_ADDR_WIDTH = 7
);
  logic                           alu_valid;
  logic                           alu_ready;
  logic [DATA_REG_ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0]          alu_data;

  logic                           mem_valid;
  logic                           mem_ready;
  logic [DATA_REG_ADDR_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0]          mem_data;

  logic                           REG_WRITE;
  logic [DATA_REG_ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0]          reg_write_data;

  // Writeback block: consumes producer results, initiates register-file writes.
  modport master (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready,
    output REG_WRITE, rd, reg_write_data
  );

  // Producers and register file side.
  modport slave (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready,
    input  REG_WRITE, rd, reg_write_data
  );
endinterface

// File: rtl/regfile_writeback.sv
// Per-lane register-file write initiator: arbitrates ALU results and a load-return FIFO into one staged write.
// Latency: ALU accept -> write next cycle; load push -> stage next cycle -> write the cycle after (earliest, UPDATE only).
// Backpressure: alu_ready needs a free slot and a non-full FIFO; mem_ready tracks registered FIFO occupancy only.
`ifndef SIMD_UPDATE
`define SIMD_UPDATE 3'd3
`endif

module regfile_writeback #(
  parameter int DATA_WIDTH          = 64,
  parameter int DATA_REG_ADDR_WIDTH = 7,
  parameter int NUM_GP_REGS         = 28,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        flush,
  input  logic [2:0]                  simd_state,
  regfile_writeback_if.master         bus,
  output logic [$clog2(FIFO_DEPTH):0] pending,
  output logic                        wb_idle,
  output logic                        illegal_wr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = DATA_REG_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] GP_LIMIT = AW'(NUM_GP_REGS);

  // Load-return FIFO storage and control.
  logic [AW-1:0] fifo_rd_q  [FIFO_DEPTH];
  logic [DW-1:0] fifo_dat_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Single staged write slot.
  logic          stage_vld_q, stage_vld_d;
  logic [AW-1:0] stage_rd_q, stage_rd_d;
  logic [DW-1:0] stage_dat_q, stage_dat_d;
  logic          illegal_q, illegal_d;

  logic fifo_full, fifo_empty, update_phase, reg_write, slot_free;
  logic alu_rdy, mem_rdy, alu_fire, mem_fire, alu_legal, mem_legal;
  logic fifo_push, fifo_pop;

  // Handshake, arbitration and write-strobe decode.
  always_comb begin
    fifo_full    = (cnt_q == FULL_CNT);
    fifo_empty   = (cnt_q == '0);
    update_phase = (simd_state == `SIMD_UPDATE);
    // Flush suppresses the strobe in the same cycle it discards the slot.
    reg_write    = stage_vld_q & enable & update_phase & ~flush;
    slot_free    = ~stage_vld_q | reg_write;
    // A full FIFO takes the slot ahead of the ALU so loads cannot starve.
    alu_rdy      = rst & enable & ~flush & slot_free & ~fifo_full;
    // Registered count only: a pop while full does not re-open the port this cycle.
    mem_rdy      = rst & enable & ~flush & ~fifo_full;
    alu_fire     = bus.alu_valid & alu_rdy;
    mem_fire     = bus.mem_valid & mem_rdy;
    alu_legal    = (bus.alu_rd < GP_LIMIT);
    mem_legal    = (bus.mem_rd < GP_LIMIT);
    // Illegal loads are acknowledged but never enqueued.
    fifo_push    = mem_fire & mem_legal;
    // An accepted ALU result owns the slot this cycle, even if it is then dropped.
    fifo_pop     = enable & ~flush & slot_free & ~fifo_empty & ~alu_fire;
  end

  // Next-state for FIFO pointers, occupancy, stage slot and sticky illegal flag.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    stage_vld_d = stage_vld_q;
    stage_rd_d  = stage_rd_q;
    stage_dat_d = stage_dat_q;
    illegal_d   = illegal_q | (alu_fire & ~alu_legal) | (mem_fire & ~mem_legal);

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      stage_vld_d = 1'b0;
    end else begin
      if (fifo_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase

      if (slot_free) begin
        if (alu_fire) begin
          stage_vld_d = alu_legal;
          if (alu_legal) begin
            stage_rd_d  = bus.alu_rd;
            stage_dat_d = bus.alu_data;
          end
        end else if (fifo_pop) begin
          stage_vld_d = 1'b1;
          stage_rd_d  = fifo_rd_q[rd_ptr_q];
          stage_dat_d = fifo_dat_q[rd_ptr_q];
        end else begin
          stage_vld_d = 1'b0;
        end
      end
    end
  end

  // Control and slot registers; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      stage_vld_q <= 1'b0;
      stage_rd_q  <= '0;
      stage_dat_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      stage_vld_q <= stage_vld_d;
      stage_rd_q  <= stage_rd_d;
      stage_dat_q <= stage_dat_d;
      illegal_q   <= illegal_d;
    end
  end

  // FIFO payload storage; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_rd_q[wr_ptr_q]  <= bus.mem_rd;
      fifo_dat_q[wr_ptr_q] <= bus.mem_data;
    end
  end

  assign bus.alu_ready      = alu_rdy;
  assign bus.mem_ready      = mem_rdy;
  assign bus.REG_WRITE      = reg_write;
  assign bus.rd             = stage_rd_q;
  assign bus.reg_write_data = stage_dat_q;
  assign pending            = cnt_q;
  assign wb_idle            = fifo_empty & ~stage_vld_q;
  assign illegal_wr         = illegal_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed vector table, corner sequences, random vs queue model.
// Latency: checks sampled 1 time unit after each rising edge, after inputs settle.
// Backpressure: producers hold their request until the matching ready is seen.
`ifndef SIMD_UPDATE
`define SIMD_UPDATE 3'd3
`endif

module tb_regfile_writeback;
  localparam int DW = 64;
  localparam int AW = 7;
  localparam int NGP = 28;
  localparam int FD = 4;
  localparam logic [2:0] UPD = `SIMD_UPDATE;
  localparam logic [2:0] IDL = `SIMD_UPDATE ^ 3'd1;

  logic          clk, rst, enable, flush;
  logic [2:0]    simd_state;
  logic [2:0]    pending;
  logic          wb_idle, illegal_wr;

  regfile_writeback_if #(.DATA_WIDTH(DW), .DATA_REG_ADDR_WIDTH(AW)) bus ();

  regfile_writeback #(.DATA_WIDTH(DW), .DATA_REG_ADDR_WIDTH(AW), .NUM_GP_REGS(NGP), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .simd_state(simd_state),
    .bus(bus), .pending(pending), .wb_idle(wb_idle), .illegal_wr(illegal_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [6:0] ard, input logic [63:0] ad,
                       input logic mv, input logic [6:0] mrd, input logic [63:0] md,
                       input logic [2:0] st);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
    simd_state = st;
  endtask

  // Directed vector record: per-cycle inputs and the outputs expected in that cycle.
  typedef struct {
    logic av; logic [6:0] ard; logic [63:0] ad;
    logic mv; logic [6:0] mrd; logic [63:0] md;
    logic upd;
    logic e_ar; logic e_mr; logic e_rw; logic [6:0] e_rd; logic [63:0] e_dat;
    int e_pend; logic e_idle;
  } vec_t;

  function automatic vec_t mk(logic av, int ard, logic [63:0] ad, logic mv, int mrd, logic [63:0] md, logic upd,
                              logic ar, logic mr, logic rw, int erd, logic [63:0] edat, int pend, logic idle);
    vec_t v;
    v.av = av; v.ard = 7'(ard); v.ad = ad; v.mv = mv; v.mrd = 7'(mrd); v.md = md; v.upd = upd;
    v.e_ar = ar; v.e_mr = mr; v.e_rw = rw; v.e_rd = 7'(erd); v.e_dat = edat; v.e_pend = pend; v.e_idle = idle;
    return v;
  endfunction

  // Reference model: FIFO as a queue, stage as one optional entry.
  typedef struct { logic [6:0] rd; logic [63:0] d; } ent_t;
  ent_t mq[$];
  logic m_sv, m_ill;
  ent_t m_st;

  vec_t vt[20];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic a_pend, m_pend, e_rw, e_ar, e_mr, free, full, afire, mfire;
    logic [6:0] a_rd, mm_rd;
    logic [63:0] a_d, mm_d;

    rst = 1'b1; enable = 1'b1; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, IDL);
    #1 rst = 1'b0;
    #1;
    chk("rst.alu_ready", 64'(bus.alu_ready), 0);
    chk("rst.mem_ready", 64'(bus.mem_ready), 0);
    chk("rst.reg_write", 64'(bus.REG_WRITE), 0);
    chk("rst.rd", 64'(bus.rd), 0);
    chk("rst.data", bus.reg_write_data, 0);
    chk("rst.pending", 64'(pending), 0);
    chk("rst.wb_idle", 64'(wb_idle), 1);
    chk("rst.illegal", 64'(illegal_wr), 0);
    @(negedge clk) rst = 1'b1;
    cyc();

    // ---- table: single ALU write, ALU+mem collision, FIFO fill / anti-starvation drain
    vt[0]  = mk(1, 5, 64'hDEAD, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 1);
    vt[1]  = mk(0, 0, 0, 0, 0, 0, 1,          1, 1, 1, 5, 64'hDEAD, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 1,          1, 1, 0, 5, 64'hDEAD, 0, 1);
    vt[3]  = mk(1, 1, 64'h11, 1, 2, 64'h22, 1, 1, 1, 0, 5, 64'hDEAD, 0, 1);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, 1,          1, 1, 1, 1, 64'h11, 1, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, 0, 1,          1, 1, 1, 2, 64'h22, 0, 0);
    vt[6]  = mk(0, 0, 0, 0, 0, 0, 1,          1, 1, 0, 2, 64'h22, 0, 1);
    vt[7]  = mk(0, 0, 0, 1, 10, 64'hA0, 0,    1, 1, 0, 2, 64'h22, 0, 1);
    vt[8]  = mk(0, 0, 0, 1, 11, 64'hA1, 0,    1, 1, 0, 2, 64'h22, 1, 0);
    vt[9]  = mk(0, 0, 0, 1, 12, 64'hA2, 0,    0, 1, 0, 10, 64'hA0, 1, 0);
    vt[10] = mk(0, 0, 0, 1, 13, 64'hA3, 0,    0, 1, 0, 10, 64'hA0, 2, 0);
    vt[11] = mk(0, 0, 0, 1, 14, 64'hA4, 0,    0, 1, 0, 10, 64'hA0, 3, 0);
    vt[12] = mk(1, 7, 64'h77, 1, 15, 64'hA5, 0, 0, 0, 0, 10, 64'hA0, 4, 0);
    vt[13] = mk(1, 7, 64'h77, 0, 0, 0, 1,     0, 0, 1, 10, 64'hA0, 4, 0);
    vt[14] = mk(1, 7, 64'h77, 0, 0, 0, 1,     1, 1, 1, 11, 64'hA1, 3, 0);
    vt[15] = mk(0, 0, 0, 0, 0, 0, 1,          1, 1, 1, 7, 64'h77, 3, 0);
    vt[16] = mk(0, 0, 0, 0, 0, 0, 1,          1, 1, 1, 12, 64'hA2, 2, 0);
    vt[17] = mk(0, 0, 0, 0, 0, 0, 1,          1, 1, 1, 13, 64'hA3, 1, 0);
    vt[18] = mk(0, 0, 0, 0, 0, 0, 1,          1, 1, 1, 14, 64'hA4, 0, 0);
    vt[19] = mk(0, 0, 0, 0, 0, 0, 1,          1, 1, 0, 14, 64'hA4, 0, 1);
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].av, vt[i].ard, vt[i].ad, vt[i].mv, vt[i].mrd, vt[i].md, vt[i].upd ? UPD : IDL);
      #1;
      chk($sformatf("vec%0d.alu_ready", i), 64'(bus.alu_ready), 64'(vt[i].e_ar));
      chk($sformatf("vec%0d.mem_ready", i), 64'(bus.mem_ready), 64'(vt[i].e_mr));
      chk($sformatf("vec%0d.reg_write", i), 64'(bus.REG_WRITE), 64'(vt[i].e_rw));
      chk($sformatf("vec%0d.rd", i), 64'(bus.rd), 64'(vt[i].e_rd));
      chk($sformatf("vec%0d.data", i), bus.reg_write_data, vt[i].e_dat);
      chk($sformatf("vec%0d.pending", i), 64'(pending), 64'(vt[i].e_pend));
      chk($sformatf("vec%0d.wb_idle", i), 64'(wb_idle), 64'(vt[i].e_idle));
      cyc();
    end

    // ---- staged ALU write held through non-UPDATE cycles, second request stalls
    drive(1, 3, 64'h33, 0, 0, 0, IDL); #1;
    chk("hold.first_ready", 64'(bus.alu_ready), 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(1, 4, 64'h44, 0, 0, 0, IDL); #1;
      chk($sformatf("hold%0d.alu_ready", i), 64'(bus.alu_ready), 0);
      chk($sformatf("hold%0d.reg_write", i), 64'(bus.REG_WRITE), 0);
      chk($sformatf("hold%0d.rd", i), 64'(bus.rd), 3);
      chk($sformatf("hold%0d.data", i), bus.reg_write_data, 64'h33);
      cyc();
    end
    drive(1, 4, 64'h44, 0, 0, 0, UPD); #1;
    chk("hold.wr_rw", 64'(bus.REG_WRITE), 1);
    chk("hold.wr_rd", 64'(bus.rd), 3);
    chk("hold.second_ready", 64'(bus.alu_ready), 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0, UPD); #1;
    chk("hold.next_rw", 64'(bus.REG_WRITE), 1);
    chk("hold.next_rd", 64'(bus.rd), 4);
    cyc();
    chk("hold.done_rw", 64'(bus.REG_WRITE), 0);
    chk("hold.done_idle", 64'(wb_idle), 1);

    // ---- randomized traffic against the queue model
    rst = 1'b0; #2 rst = 1'b1; #2;
    mq.delete(); m_sv = 1'b0; m_ill = 1'b0; m_st = '{rd: 7'd0, d: 64'd0};
    a_pend = 1'b0; m_pend = 1'b0; a_rd = '0; a_d = '0; mm_rd = '0; mm_d = '0;
    for (int c = 0; c < 2000; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 39) == 0);
      simd_state = ($urandom_range(0, 1) != 0) ? UPD : IDL;
      if (!a_pend && $urandom_range(0, 1) != 0) begin
        a_pend = 1'b1; a_rd = 7'($urandom_range(0, 31)); a_d = {$urandom, $urandom};
      end
      if (!m_pend && $urandom_range(0, 2) != 0) begin
        m_pend = 1'b1; mm_rd = 7'($urandom_range(0, 31)); mm_d = {$urandom, $urandom};
      end
      bus.alu_valid = a_pend; bus.alu_rd = a_rd; bus.alu_data = a_d;
      bus.mem_valid = m_pend; bus.mem_rd = mm_rd; bus.mem_data = mm_d;
      #1;
      full = (mq.size() == FD);
      e_rw = m_sv && enable && (simd_state == UPD) && !flush;
      free = !m_sv || e_rw;
      e_ar = enable && !flush && free && !full;
      e_mr = enable && !flush && !full;
      chk("rnd.alu_ready", 64'(bus.alu_ready), 64'(e_ar));
      chk("rnd.mem_ready", 64'(bus.mem_ready), 64'(e_mr));
      chk("rnd.reg_write", 64'(bus.REG_WRITE), 64'(e_rw));
      if (e_rw) begin
        chk("rnd.rd", 64'(bus.rd), 64'(m_st.rd));
        chk("rnd.data", bus.reg_write_data, m_st.d);
      end
      chk("rnd.pending", 64'(pending), 64'(mq.size()));
      chk("rnd.wb_idle", 64'(wb_idle), 64'(mq.size() == 0 && !m_sv));
      chk("rnd.illegal", 64'(illegal_wr), 64'(m_ill));
      afire = a_pend && e_ar;
      mfire = m_pend && e_mr;
      if (afire && a_rd >= NGP) m_ill = 1'b1;
      if (mfire && mm_rd >= NGP) m_ill = 1'b1;
      if (flush) begin
        mq.delete();
        m_sv = 1'b0;
      end else begin
        if (free) begin
          if (afire) begin
            m_sv = (a_rd < NGP);
            if (m_sv) m_st = '{rd: a_rd, d: a_d};
          end else if (enable && mq.size() > 0) begin
            m_st = mq.pop_front();
            m_sv = 1'b1;
          end else begin
            m_sv = 1'b0;
          end
        end
        if (mfire && mm_rd < NGP) mq.push_back('{rd: mm_rd, d: mm_d});
      end
      if (afire) a_pend = 1'b0;
      if (mfire) m_pend = 1'b0;
      cyc();
    end

    // ---- illegal destinations: acknowledged, dropped, sticky flag
    enable = 1'b1; flush = 1'b0;
    rst = 1'b0; #2 rst = 1'b1; #2;
    drive(1, 29, 64'h1, 0, 0, 0, UPD); #1;
    chk("ill.alu_ready", 64'(bus.alu_ready), 1);
    cyc();
    drive(0, 0, 0, 1, 31, 64'h2, UPD); #1;
    chk("ill.alu_rw", 64'(bus.REG_WRITE), 0);
    chk("ill.alu_idle", 64'(wb_idle), 1);
    chk("ill.alu_flag", 64'(illegal_wr), 1);
    chk("ill.mem_ready", 64'(bus.mem_ready), 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0, UPD); #1;
    chk("ill.mem_pending", 64'(pending), 0);
    chk("ill.mem_rw", 64'(bus.REG_WRITE), 0);
    chk("ill.mem_idle", 64'(wb_idle), 1);
    cyc(); cyc(); cyc();
    chk("ill.sticky", 64'(illegal_wr), 1);

    // ---- enable=0 hold, then flush with three queued entries and a staged write
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 1, 7'(i), 64'(i), IDL);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, IDL); #1;
    chk("fl.pending3", 64'(pending), 3);
    chk("fl.staged_rd", 64'(bus.rd), 1);
    for (int i = 0; i < 2; i++) begin
      enable = 1'b0;
      drive(1, 5, 64'h5, 1, 9, 64'h9, UPD); #1;
      chk($sformatf("en0_%0d.rw", i), 64'(bus.REG_WRITE), 0);
      chk($sformatf("en0_%0d.alu_ready", i), 64'(bus.alu_ready), 0);
      chk($sformatf("en0_%0d.mem_ready", i), 64'(bus.mem_ready), 0);
      chk($sformatf("en0_%0d.pending", i), 64'(pending), 3);
      cyc();
    end
    enable = 1'b1; flush = 1'b1;
    drive(0, 0, 0, 0, 0, 0, UPD); #1;
    chk("fl.rw", 64'(bus.REG_WRITE), 0);
    chk("fl.alu_ready", 64'(bus.alu_ready), 0);
    chk("fl.mem_ready", 64'(bus.mem_ready), 0);
    cyc();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, UPD); #1;
    chk("fl.pending0", 64'(pending), 0);
    chk("fl.idle", 64'(wb_idle), 1);
    chk("fl.after_rw", 64'(bus.REG_WRITE), 0);
    chk("fl.illegal_kept", 64'(illegal_wr), 1);

    // ---- reset in the middle of a drain
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 1, 7'(i), 64'(i), IDL);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, UPD); #1;
    chk("rd.pending4", 64'(pending), 4);
    chk("rd.rw1", 64'(bus.REG_WRITE), 1);
    chk("rd.rd1", 64'(bus.rd), 1);
    cyc();
    chk("rd.rw2", 64'(bus.REG_WRITE), 1);
    chk("rd.rd2", 64'(bus.rd), 2);
    chk("rd.pending3", 64'(pending), 3);
    #2 rst = 1'b0;
    #1;
    chk("rd.rst_rw", 64'(bus.REG_WRITE), 0);
    chk("rd.rst_rd", 64'(bus.rd), 0);
    chk("rd.rst_data", bus.reg_write_data, 0);
    chk("rd.rst_pending", 64'(pending), 0);
    chk("rd.rst_idle", 64'(wb_idle), 1);
    chk("rd.rst_alu_ready", 64'(bus.alu_ready), 0);
    chk("rd.rst_mem_ready", 64'(bus.mem_ready), 0);
    chk("rd.rst_illegal", 64'(illegal_wr), 0);
    #1 rst = 1'b1;
    cyc();
    chk("rd.post_rw", 64'(bus.REG_WRITE), 0);
    chk("rd.post_idle", 64'(wb_idle), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
